// File: rtl/csi_rx_align_ctrl_pkg.sv
// Shared types and default timing constants for the CSI-2 receive alignment controller.
package csi_rx_align_ctrl_pkg;

   localparam int NUM_LANE = 2;
   typedef logic [NUM_LANE-1:0] lane_vld_t;

   // Supervisor states; the encoding is visible on state_o for debug.
   typedef enum logic [2:0] {
      ST_DISABLED = 3'd0,
      ST_HUNT     = 3'd1,
      ST_LOCKED   = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_BACKOFF  = 3'd4
   } align_state_t;

   localparam int ALIGN_TIMEOUT_CYC = 64;
   localparam int ALIGN_BACKOFF_CYC = 8;
   localparam int ALIGN_DRAIN_CYC   = 2;
   localparam int ALIGN_CNT_W       = 16;

   // Largest of three cycle counts; sizes the shared state timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/csi_rx_sat_counter.sv
// Saturating up-counter used for the packet and error statistics.
module csi_rx_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise increment until all-ones and hold there.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/csi_rx_align_ctrl.sv
// Supervisory FSM sequencing the CSI-2 word aligner: hunts for sync, tracks lock,
// forces a resync with backoff on timeout or lock loss, and keeps statistics.
module csi_rx_align_ctrl
   import csi_rx_align_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = ALIGN_TIMEOUT_CYC,
   parameter int BACKOFF_CYC = ALIGN_BACKOFF_CYC,
   parameter int DRAIN_CYC   = ALIGN_DRAIN_CYC,
   parameter int CNT_W       = ALIGN_CNT_W
) (
   input  logic             byte_clock,
   input  logic             reset,
   input  logic             ctrl_enable,
   input  lane_vld_t        lane_vld,
   input  logic             word_valid,
   input  logic             pkt_done_in,
   output logic             align_enable,
   output logic             wait_for_sync,
   output logic             pkt_done_out,
   output logic             locked,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // One timer serves hunt, drain and backoff; it only ever counts to its limit minus one.
   localparam int TMR_MAX = max3(TIMEOUT_CYC, BACKOFF_CYC, DRAIN_CYC);
   localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] BKO_LAST = TMR_W'(BACKOFF_CYC - 1);
   localparam logic [TMR_W-1:0] DRN_LAST = TMR_W'(DRAIN_CYC - 1);

   align_state_t     state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             force_q, force_d;
   logic             pkt_inc, err_inc;

   // Next-state, timer and force logic; disable overrides everything but reset.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      force_d = 1'b0;
      pkt_inc = 1'b0;
      err_inc = 1'b0;
      if (!ctrl_enable) begin
         state_d = ST_DISABLED;
         timer_d = '0;
         // Unlock the aligners when leaving any state in which they may hold sync.
         force_d = (state_q == ST_LOCKED) || (state_q == ST_HUNT) || (state_q == ST_BACKOFF);
      end else begin
         case (state_q)
            ST_DISABLED: begin
               state_d = ST_HUNT;
               timer_d = '0;
            end
            ST_HUNT: begin
               if (pkt_done_in) begin
                  timer_d = '0;
               end else if (word_valid) begin
                  state_d = ST_LOCKED;
                  timer_d = '0;
               end else if (timer_q == TMO_LAST) begin
                  err_inc = 1'b1;
                  state_d = ST_BACKOFF;
                  timer_d = '0;
               end else if (|lane_vld) begin
                  timer_d = timer_q + 1'b1;
               end else begin
                  timer_d = '0;
               end
            end
            ST_LOCKED: begin
               // A packet end coinciding with word_valid falling is a packet, not an error.
               if (pkt_done_in) begin
                  pkt_inc = 1'b1;
                  state_d = ST_DRAIN;
                  timer_d = '0;
               end else if (!word_valid) begin
                  err_inc = 1'b1;
                  state_d = ST_BACKOFF;
                  timer_d = '0;
               end
            end
            ST_DRAIN: begin
               if (timer_q == DRN_LAST) begin
                  state_d = ST_HUNT;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            ST_BACKOFF: begin
               if (timer_q == BKO_LAST) begin
                  state_d = ST_HUNT;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_DISABLED;
               timer_d = '0;
            end
         endcase
         // Force packet_done for every cycle spent in backoff.
         force_d = (state_d == ST_BACKOFF);
      end
   end

   // State, timer and force registers.
   always_ff @(posedge byte_clock) begin
      if (reset) begin
         state_q <= ST_DISABLED;
         timer_q <= '0;
         force_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         force_q <= force_d;
      end
   end

   // Moore decode of the aligner controls from the registered state.
   always_comb begin
      align_enable  = 1'b0;
      wait_for_sync = 1'b0;
      locked        = 1'b0;
      case (state_q)
         ST_HUNT:    begin align_enable = 1'b1; wait_for_sync = 1'b1; end
         ST_LOCKED:  begin align_enable = 1'b1; locked = 1'b1; end
         ST_DRAIN:   align_enable = 1'b1;
         ST_BACKOFF: align_enable = 1'b1;
         default:    ;
      endcase
   end

   assign state_o      = state_q;
   assign pkt_done_out = pkt_done_in | force_q;

   csi_rx_sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
      .clk_i   (byte_clock),
      .reset_i (reset),
      .clear_i (1'b0),
      .inc_i   (pkt_inc),
      .cnt_o   (pkt_cnt)
   );

   csi_rx_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk_i   (byte_clock),
      .reset_i (reset),
      .clear_i (1'b0),
      .inc_i   (err_inc),
      .cnt_o   (err_cnt)
   );

endmodule

// File: tb/tb_csi_rx_align_ctrl.sv
// Bench for csi_rx_align_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_csi_rx_align_ctrl;
   import csi_rx_align_ctrl_pkg::*;

   localparam int TMO = 64;
   localparam int BKO = 8;
   localparam int DRN = 2;

   // ---------------- clock / reset ----------------
   logic      clk = 1'b0;
   logic      reset = 1'b1;
   logic      en = 1'b0;
   lane_vld_t lv = '0;
   logic      wv = 1'b0;
   logic      pd = 1'b0;

   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   logic        ae, wfs, pdo, lck;
   logic [2:0]  st;
   logic [15:0] pkc, erc;
   logic        s_ae, s_wfs, s_pdo, s_lck;
   logic [2:0]  s_st;
   logic [3:0]  s_pkc, s_erc;

   csi_rx_align_ctrl dut (
      .byte_clock(clk), .reset(reset), .ctrl_enable(en), .lane_vld(lv),
      .word_valid(wv), .pkt_done_in(pd), .align_enable(ae), .wait_for_sync(wfs),
      .pkt_done_out(pdo), .locked(lck), .state_o(st), .pkt_cnt(pkc), .err_cnt(erc)
   );

   // Narrow-counter build to reach saturation quickly.
   csi_rx_align_ctrl #(.CNT_W(4)) dut_s (
      .byte_clock(clk), .reset(reset), .ctrl_enable(en), .lane_vld(lv),
      .word_valid(wv), .pkt_done_in(pd), .align_enable(s_ae), .wait_for_sync(s_wfs),
      .pkt_done_out(s_pdo), .locked(s_lck), .state_o(s_st), .pkt_cnt(s_pkc), .err_cnt(s_erc)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 disabled, 1 hunting, 2 locked, 3 draining, 4 backing off.
   // run: consecutive lane-valid hunt cycles; hold: cycles left in drain/backoff.
   int m_mode = 0, m_run = 0, m_hold = 0, m_pk = 0, m_er = 0;
   bit m_frc = 0;

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_step();
      bit nfrc;
      if (reset) begin
         m_mode = 0; m_run = 0; m_hold = 0; m_frc = 0; m_pk = 0; m_er = 0;
         return;
      end
      nfrc = 0;
      if (!en) begin
         nfrc = (m_mode == 1) || (m_mode == 2) || (m_mode == 4);
         m_mode = 0;
         m_run = 0;
      end else begin
         case (m_mode)
            0: begin m_mode = 1; m_run = 0; end
            1: begin
               if (pd) m_run = 0;
               else if (wv) m_mode = 2;
               else if (m_run == TMO - 1) begin m_er++; m_mode = 4; m_hold = BKO; m_run = 0; end
               else if (lv != '0) m_run++;
               else m_run = 0;
            end
            2: begin
               if (pd) begin m_pk++; m_mode = 3; m_hold = DRN; end
               else if (!wv) begin m_er++; m_mode = 4; m_hold = BKO; end
            end
            3, 4: begin
               m_hold--;
               if (m_hold == 0) begin m_mode = 1; m_run = 0; end
            end
            default: ;
         endcase
         nfrc = (m_mode == 4);
      end
      m_frc = nfrc;
   endtask

   // Compare process: every cycle, 1 time unit after inputs change, then advance the model.
   always @(negedge clk) begin
      #1;
      check("state_o",       32'(st),    32'(m_mode));
      check("align_enable",  32'(ae),    32'(m_mode != 0));
      check("wait_for_sync", 32'(wfs),   32'(m_mode == 1));
      check("locked",        32'(lck),   32'(m_mode == 2));
      check("pkt_done_out",  32'(pdo),   32'(pd | m_frc));
      check("pkt_cnt",       32'(pkc),   32'(sat(m_pk, 65535)));
      check("err_cnt",       32'(erc),   32'(sat(m_er, 65535)));
      check("s_state_o",     32'(s_st),  32'(m_mode));
      check("s_pkt_done",    32'(s_pdo), 32'(pd | m_frc));
      check("s_pkt_cnt",     32'(s_pkc), 32'(sat(m_pk, 15)));
      check("s_err_cnt",     32'(s_erc), 32'(sat(m_er, 15)));
      model_step();
   end

   // ---------------- driver ----------------
   task automatic cyc(input logic e, input lane_vld_t l, input logic w, input logic p);
      @(negedge clk);
      en = e; lv = l; wv = w; pd = p;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int hunt_n, bo_n, len, kind;
      logic      e, w, p;
      lane_vld_t l;

      // Reset state
      cyc(0, 2'b00, 0, 0);
      cyc(0, 2'b00, 0, 0);
      #2;
      check("rst_state", 32'(st), 0);
      check("rst_ae", 32'(ae), 0);
      check("rst_pdo", 32'(pdo), 0);
      check("rst_cnt", 32'({pkc, erc}), 0);

      // Enable: first cycle after is HUNT
      cyc(1, 2'b00, 0, 0);
      reset = 1'b0;
      cyc(1, 2'b11, 0, 0);
      #2;
      check("en_state", 32'(st), 1);
      check("en_ae_wfs", 32'({ae, wfs, lck}), 32'b110);

      // Normal packet
      repeat (8) cyc(1, 2'b11, 0, 0);
      cyc(1, 2'b11, 1, 0);
      cyc(1, 2'b11, 1, 0);
      #2;
      check("lock_rise", 32'(lck), 1);
      repeat (18) cyc(1, 2'b11, 1, 0);
      cyc(1, 2'b11, 1, 1);
      #2;
      check("pkt_pdo", 32'({pdo, lck}), 32'b11);
      cyc(1, 2'b11, 0, 0);
      #2;
      check("drain1", 32'(st), 3);
      check("pkt_cnt1", 32'(pkc), 1);
      cyc(1, 2'b01, 0, 0);
      #2;
      check("drain2", 32'(st), 3);

      // Hunt timeout: count hunt cycles, then forced-done cycles in backoff
      cyc(1, 2'b01, 0, 0);
      #2;
      hunt_n = 0;
      for (int i = 0; i < 200 && st == 3'd1; i++) begin
         hunt_n++;
         cyc(1, 2'b01, 0, 0);
         #2;
      end
      check("hunt_len", 32'(hunt_n), 64);
      bo_n = 0;
      for (int i = 0; i < 50 && st == 3'd4; i++) begin
         if (pdo) bo_n++;
         cyc(1, 2'b01, 0, 0);
         #2;
      end
      check("backoff_len", 32'(bo_n), 8);
      check("after_bo", 32'(st), 1);
      check("err_cnt1", 32'(erc), 1);

      // Lock loss
      cyc(1, 2'b11, 1, 0);
      cyc(1, 2'b11, 0, 0);
      #2;
      check("ll_locked", 32'(st), 2);
      cyc(1, 2'b11, 0, 0);
      #2;
      check("ll_state", 32'(st), 4);
      check("ll_cnts", 32'({pkc, erc}), 32'({16'd1, 16'd2}));
      repeat (8) cyc(1, 2'b00, 0, 0);
      #2;
      check("ll_rehunt", 32'(st), 1);

      // Disable mid-lock
      cyc(1, 2'b11, 1, 0);
      cyc(0, 2'b11, 1, 0);
      #2;
      check("dis_pre", 32'(st), 2);
      cyc(0, 2'b00, 0, 0);
      #2;
      check("dis_state", 32'({st, ae, pdo}), 32'({3'd0, 1'b0, 1'b1}));
      cyc(0, 2'b00, 0, 0);
      #2;
      check("dis_pulse_end", 32'(pdo), 0);

      // Packet end coincident with word_valid fall
      cyc(1, 2'b00, 0, 0);
      cyc(1, 2'b11, 1, 0);
      cyc(1, 2'b11, 0, 1);
      #2;
      check("sim_locked", 32'(st), 2);
      cyc(1, 2'b00, 0, 0);
      #2;
      check("sim_cnts", 32'({pkc, erc}), 32'({16'd2, 16'd2}));

      // 20 timeouts: saturates the narrow error counter
      cyc(1, 2'b00, 0, 0);
      repeat (1450) cyc(1, 2'b01, 0, 0);
      #2;
      check("sat_err16", 32'(erc), 22);
      check("sat_err4", 32'(s_erc), 15);
      check("sat_pkt4", 32'(s_pkc), 2);

      // Randomized traffic in segments of differing character
      for (int s = 0; s < 60; s++) begin
         len = $urandom_range(20, 120);
         kind = $urandom_range(0, 3);
         if (s == 30) begin
            @(negedge clk);
            reset = 1'b1;
            repeat (2) cyc(1, 2'b00, 0, 0);
            reset = 1'b0;
         end
         for (int i = 0; i < len; i++) begin
            e = ($urandom_range(0, 149) != 0);
            case (kind)
               0: begin
                  l = lane_vld_t'($urandom_range(1, 3));
                  w = 1'b0;
                  p = ($urandom_range(0, 99) == 0);
               end
               1: begin
                  l = lane_vld_t'($urandom_range(0, 3));
                  w = ($urandom_range(0, 9) != 0);
                  p = ($urandom_range(0, 19) == 0);
               end
               default: begin
                  l = lane_vld_t'($urandom_range(0, 3));
                  w = ($urandom_range(0, 1) != 0);
                  p = ($urandom_range(0, 7) == 0);
               end
            endcase
            cyc(e, l, w, p);
         end
      end

      @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
